// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-byte add/subtract sequencer: byte width,
// operation encoding and the sequencer state type.
package alu_seq_pkg;

    localparam int BYTE_W = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu8_byte_add.sv
// Combinational 8-bit byte slice adder built from generate/propagate terms.
// Exposes the carry into the MSB so the sequencer can derive signed overflow.
module alu8_byte_add
    import alu_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout,
    output logic              c7
);

    logic [BYTE_W-1:0] w_gen;
    logic [BYTE_W-1:0] w_prop;
    logic [BYTE_W:0]   w_carry;

    // Ripple chain: each carry is generate OR (propagate AND incoming carry).
    always_comb begin
        w_gen      = a & b;
        w_prop     = a ^ b;
        w_carry    = '0;
        w_carry[0] = cin;
        for (int k = 0; k < BYTE_W; k++) begin
            w_carry[k+1] = w_gen[k] | (w_prop[k] & w_carry[k]);
        end
        sum  = w_prop ^ w_carry[BYTE_W-1:0];
        cout = w_carry[BYTE_W];
        c7   = w_carry[BYTE_W-1];
    end

endmodule

// File: rtl/alu_multibyte_seq.sv
// Multi-byte add/subtract sequencer driving one 8-bit slice LSB first.
// Define ALU_SEQ_FLAGS_EN to build the zero/ovf flag registers.
module alu_multibyte_seq
    import alu_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op,
    input  logic                   cin,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    output logic                   busy,
    output logic                   done,
    output logic [BYTE_W*NBYTES-1:0] result,
    output logic                   cout,
    output logic                   zero,
    output logic                   ovf
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    state_t r_state;
    state_t w_nextState;
    logic   w_accept;

    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_result;
    logic              r_op;
    logic              r_carry;
    logic              r_cout;
    logic [IW-1:0]     r_idx;

    logic [BYTE_W-1:0] w_aByte;
    logic [BYTE_W-1:0] w_bByte;
    logic [BYTE_W-1:0] w_sum;
    logic              w_byteCout;
    logic              w_lastByte;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A new start is only honoured when no operation is in flight.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_lastByte) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = RUN;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_lastByte = (r_idx == LAST_IDX);
    assign w_aByte    = r_a[r_idx*BYTE_W +: BYTE_W];
    assign w_bByte    = (r_op == OP_SUB) ? ~r_b[r_idx*BYTE_W +: BYTE_W]
                                         :  r_b[r_idx*BYTE_W +: BYTE_W];

`ifdef ALU_SEQ_FLAGS_EN
    logic w_c7;

    alu8_byte_add u_byteAdd (
        .a    (w_aByte),
        .b    (w_bByte),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_byteCout),
        .c7   (w_c7)
    );
`else
    alu8_byte_add u_byteAdd (
        .a    (w_aByte),
        .b    (w_bByte),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_byteCout),
        .c7   ()
    );
`endif

    // SUB is A + ~B + 1, so the carry register is preloaded with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ADD;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_op     <= op;
            r_idx    <= '0;
            r_carry  <= (op == OP_SUB) ? 1'b1 : cin;
            r_result <= '0;
        end else if (r_state == RUN) begin
            r_result[r_idx*BYTE_W +: BYTE_W] <= w_sum;
            r_carry  <= w_byteCout;
            r_idx    <= r_idx + 1'b1;
            if (w_lastByte) begin
                r_cout <= w_byteCout;
            end
        end
    end

    assign result = r_result;
    assign cout   = r_cout;

`ifdef ALU_SEQ_FLAGS_EN
    logic         r_zero;
    logic         r_ovf;
    logic [W-1:0] w_finalResult;

    // Zero must see the top byte being written this cycle, not the stale register.
    always_comb begin
        w_finalResult = r_result;
        w_finalResult[r_idx*BYTE_W +: BYTE_W] = w_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if ((r_state == RUN) && w_lastByte) begin
            r_zero <= (w_finalResult == '0);
            r_ovf  <= w_c7 ^ w_byteCout;
        end
    end

    assign zero = r_zero;
    assign ovf  = r_ovf;
`else
    assign zero = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Self-checking bench for alu_multibyte_seq: directed and random add/sub
// against a wide-arithmetic reference model, plus start/reset corner cases.
module tb_alu_multibyte_seq;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;
    localparam int LAT    = NBYTES + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    alu_multibyte_seq #(.NBYTES(NBYTES)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         v;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vop;
        logic         vcin;
        logic [W-1:0] eres;
        logic         ec;
        logic         ez;
        logic         ev;
    } vec_t;

    // Reference: plain W+1-bit arithmetic and sign-rule overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic sub, input logic ci);
        exp_t       e;
        logic [W:0] full;
        if (sub) full = {1'b0, x} - {1'b0, y};
        else     full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.res = full[W-1:0];
        e.c   = sub ? (x >= y) : full[W];
`ifdef ALU_SEQ_FLAGS_EN
        e.z = (e.res == '0);
        if (sub) e.v = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
        else     e.v = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
`else
        e.z = 1'b0;
        e.v = 1'b0;
`endif
        return e;
    endfunction

    // Waits (bounded) for done; n = edges waited, -1 on timeout.
    task automatic waitDone(output int n);
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge where done is high.
    task automatic doOp(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic sub, input logic ci, output int edges);
        int n;
        a = x; b = y; op = sub; cin = ci; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        waitDone(n);
        edges = (n < 0) ? -1 : n + 1;
    endtask

    task automatic applyReset();
        rst = 1'b1; start = 1'b0; op = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        applyReset();
        checks++; if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("[TB] FAIL reset_done got %b exp 0", done); end
        checks++; if (result !== '0)   begin errors++; $display("[TB] FAIL reset_result got %h exp 0", result); end
        checks++; if (cout !== 1'b0)   begin errors++; $display("[TB] FAIL reset_cout got %b exp 0", cout); end
        checks++; if (zero !== 1'b0)   begin errors++; $display("[TB] FAIL reset_zero got %b exp 0", zero); end
        checks++; if (ovf !== 1'b0)    begin errors++; $display("[TB] FAIL reset_ovf got %b exp 0", ovf); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        vec_t vecs [6];
        int   edges;
        logic flagsOn;
`ifdef ALU_SEQ_FLAGS_EN
        flagsOn = 1'b1;
`else
        flagsOn = 1'b0;
`endif
        vecs = '{
            '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0},
            '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0},
            '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0},
            '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0},
            '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1},
            '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1}
        };
        for (int i = 0; i < 6; i++) begin
            doOp(vecs[i].va, vecs[i].vb, vecs[i].vop, vecs[i].vcin, edges);
            checks++; if (edges !== LAT) begin errors++; $display("[TB] FAIL dir%0d_latency got %0d exp %0d", i, edges, LAT); end
            checks++; if (result !== vecs[i].eres) begin errors++; $display("[TB] FAIL dir%0d_result got %h exp %h", i, result, vecs[i].eres); end
            checks++; if (cout !== vecs[i].ec) begin errors++; $display("[TB] FAIL dir%0d_cout got %b exp %b", i, cout, vecs[i].ec); end
            checks++; if (zero !== (vecs[i].ez & flagsOn)) begin errors++; $display("[TB] FAIL dir%0d_zero got %b exp %b", i, zero, vecs[i].ez & flagsOn); end
            checks++; if (ovf !== (vecs[i].ev & flagsOn)) begin errors++; $display("[TB] FAIL dir%0d_ovf got %b exp %b", i, ovf, vecs[i].ev & flagsOn); end
            @(posedge clk);
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_done_width got %b exp 0", i, done); end
            checks++; if (result !== vecs[i].eres) begin errors++; $display("[TB] FAIL dir%0d_result_hold got %h exp %h", i, result, vecs[i].eres); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;
        logic         ci;
        exp_t         e;
        int           edges;
        for (int i = 0; i < 40; i++) begin
            x  = $urandom;
            y  = $urandom;
            s  = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            if (i % 5 == 0) y = x;
            if (i % 7 == 0) y = ~x;
            e = model(x, y, s, ci);
            doOp(x, y, s, ci, edges);
            checks++; if (edges !== LAT)  begin errors++; $display("[TB] FAIL rnd%0d_latency got %0d exp %0d", i, edges, LAT); end
            checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL rnd%0d_result a=%h b=%h op=%b got %h exp %h", i, x, y, s, result, e.res); end
            checks++; if (cout !== e.c)   begin errors++; $display("[TB] FAIL rnd%0d_cout got %b exp %b", i, cout, e.c); end
            checks++; if (zero !== e.z)   begin errors++; $display("[TB] FAIL rnd%0d_zero got %b exp %b", i, zero, e.z); end
            checks++; if (ovf !== e.v)    begin errors++; $display("[TB] FAIL rnd%0d_ovf got %b exp %b", i, ovf, e.v); end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] x;
        logic [W-1:0] y;
        exp_t         e;
        int           n;
        x = $urandom; y = $urandom;
        e = model(x, y, 1'b0, 1'b1);
        a = x; b = y; op = 1'b0; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = ~x; b = x; op = 1'b1; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ign_busy got %b exp 1", busy); end
        waitDone(n);
        checks++; if (n !== NBYTES - 2) begin errors++; $display("[TB] FAIL ign_latency got %0d exp %0d", n, NBYTES - 2); end
        checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL ign_result got %h exp %h", result, e.res); end
        checks++; if (cout !== e.c) begin errors++; $display("[TB] FAIL ign_cout got %b exp %b", cout, e.c); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ign_no_requeue got busy %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x1, y1, x2, y2;
        exp_t         e1, e2;
        int           edges;
        int           n;
        x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
        e1 = model(x1, y1, 1'b1, 1'b0);
        e2 = model(x2, y2, 1'b0, 1'b0);
        doOp(x1, y1, 1'b1, 1'b0, edges);
        checks++; if (result !== e1.res) begin errors++; $display("[TB] FAIL b2b_first_result got %h exp %h", result, e1.res); end
        a = x2; b = y2; op = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy got %b exp 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done got %b exp 0", done); end
        waitDone(n);
        checks++; if (n !== NBYTES) begin errors++; $display("[TB] FAIL b2b_latency got %0d exp %0d", n, NBYTES); end
        checks++; if (result !== e2.res) begin errors++; $display("[TB] FAIL b2b_second_result got %h exp %h", result, e2.res); end
        checks++; if (cout !== e2.c) begin errors++; $display("[TB] FAIL b2b_second_cout got %b exp %b", cout, e2.c); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int   edges;
        int   sawDone;
        exp_t e;
        doOp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, edges);
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; op = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstrun_busy got %b exp 0", busy); end
        checks++; if (result !== '0) begin errors++; $display("[TB] FAIL rstrun_result got %h exp 0", result); end
        checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL rstrun_cout got %b exp 0", cout); end
        checks++; if (zero !== 1'b0) begin errors++; $display("[TB] FAIL rstrun_zero got %b exp 0", zero); end
        sawDone = 0;
        for (int k = 0; k < 8; k++) begin
            if (done === 1'b1) sawDone++;
            @(negedge clk);
        end
        checks++; if (sawDone !== 0) begin errors++; $display("[TB] FAIL rstrun_no_done got %0d pulses exp 0", sawDone); end
        e = model(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        doOp(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, edges);
        checks++; if (edges !== LAT) begin errors++; $display("[TB] FAIL rstrun_after_latency got %0d exp %0d", edges, LAT); end
        checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL rstrun_after_result got %h exp %h", result, e.res); end
        checks++; if (ovf !== e.v) begin errors++; $display("[TB] FAIL rstrun_after_ovf got %b exp %b", ovf, e.v); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
